// File: rtl/off_chip_rx.sv
// Off-chip link receiver: buffers 4-bit link words, pairs them into bytes and returns credits.
// Optional sticky overflow flag enabled by defining OFF_CHIP_RX_OVF_CHECK_EN.
module off_chip_rx #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lnk_valid,
  input  logic [3:0] lnk_data,
  output logic       lnk_credit,
  output logic [7:0] data_out,
  output logic       valid_out,
  input  logic       ready,
  output logic       ovf_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_LO, S_HI, S_OUT} state_e;

  state_e     state_q, state_d;
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [3:0] mem_q [DEPTH];
  logic [3:0] lo_q, lo_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       credit_q, credit_d;
  logic       empty, full, push, pop;
  logic [3:0] rdWord;

  assign empty  = (wptr_q == rptr_q);
  assign full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign push   = lnk_valid && !full;
  assign rdWord = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= lnk_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_LO;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LO:    if (!empty) state_d = S_HI;
      S_HI:    if (!empty) state_d = S_OUT;
      S_OUT:   if (ready)  state_d = empty ? S_LO : S_HI;
      default: state_d = S_LO;
    endcase
  end

  // In S_OUT an accepted byte may immediately pop the next low word.
  always_comb begin
    pop     = 1'b0;
    lo_d    = lo_q;
    data_d  = data_q;
    valid_d = valid_q;
    case (state_q)
      S_LO: begin
        if (!empty) begin
          pop  = 1'b1;
          lo_d = rdWord;
        end
      end
      S_HI: begin
        if (!empty) begin
          pop     = 1'b1;
          data_d  = {rdWord[3:2], lo_q[3:2], rdWord[1:0], lo_q[1:0]};
          valid_d = 1'b1;
        end
      end
      S_OUT: begin
        if (ready) begin
          valid_d = 1'b0;
          if (!empty) begin
            pop  = 1'b1;
            lo_d = rdWord;
          end
        end
      end
      default: begin
        pop     = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign wptr_d   = wptr_q + {{AW{1'b0}}, push};
  assign rptr_d   = rptr_q + {{AW{1'b0}}, pop};
  assign credit_d = pop && (&rptr_q[AW-2:0]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      lo_q     <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      credit_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      lo_q     <= lo_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      credit_q <= credit_d;
    end
  end

  assign data_out   = data_q;
  assign valid_out  = valid_q;
  assign lnk_credit = credit_q;

`ifdef OFF_CHIP_RX_OVF_CHECK_EN
  logic ovf_q, ovf_d;

  assign ovf_d = ovf_q | (lnk_valid && full);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_err = ovf_q;
`else
  assign ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_off_chip_rx.sv
// Self-checking bench for off_chip_rx: queue-based reference model plus directed scenarios.
module tb_off_chip_rx;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lnk_valid;
  logic [3:0] lnk_data;
  logic       ready;
  logic       lnk_credit;
  logic [7:0] data_out;
  logic       valid_out;
  logic       ovf_err;

  int assertCount = 0;
  int failCount   = 0;

  off_chip_rx #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lnk_valid  (lnk_valid),
    .lnk_data   (lnk_data),
    .lnk_credit (lnk_credit),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .ready      (ready),
    .ovf_err    (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] joinWords(input logic [3:0] lo, input logic [3:0] hi);
    return {hi[3:2], lo[3:2], hi[1:0], lo[1:0]};
  endfunction

  // Reference model: a word queue of DEPTH entries feeding a lo/hi pairing stage.
  logic [3:0] mQ[$];
  bit         mHaveLo;
  logic [3:0] mLo;
  bit         mValid;
  logic [7:0] mByte;
  bit         mCredit;
  bit         mOvf;
  int         mPops;
  bit         modelLive = 1'b0;
  bit         mWasFull;
  bit         mDidPop;
  logic [3:0] mWord;

  always @(posedge clk) begin
    if (rst_n === 1'b0) begin
      mQ.delete();
      mHaveLo   = 1'b0;
      mLo       = '0;
      mValid    = 1'b0;
      mByte     = '0;
      mCredit   = 1'b0;
      mOvf      = 1'b0;
      mPops     = 0;
      modelLive = 1'b1;
    end else if (modelLive) begin
      mWasFull = (mQ.size() == DEPTH);
      mDidPop  = 1'b0;
      if ((!mValid || ready) && mQ.size() > 0) begin
        mWord   = mQ.pop_front();
        mDidPop = 1'b1;
        if (!mHaveLo) begin
          mLo     = mWord;
          mHaveLo = 1'b1;
          mValid  = 1'b0;
        end else begin
          mByte   = joinWords(mLo, mWord);
          mValid  = 1'b1;
          mHaveLo = 1'b0;
        end
      end else if (mValid && ready) begin
        mValid = 1'b0;
      end
      mCredit = mDidPop && ((mPops % (DEPTH / 2)) == (DEPTH / 2 - 1));
      if (mDidPop) mPops++;
      if (lnk_valid && !mWasFull) mQ.push_back(lnk_data);
`ifdef OFF_CHIP_RX_OVF_CHECK_EN
      if (lnk_valid && mWasFull) mOvf = 1'b1;
`endif
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (modelLive) begin
      checkOutput("valid_out", valid_out, mValid);
      if (mValid) checkOutput("data_out", data_out, mByte);
      checkOutput("lnk_credit", lnk_credit, mCredit);
      checkOutput("ovf_err", ovf_err, mOvf);
    end
  end

  // Record accepted bytes and credit pulses for the directed checks.
  logic [7:0] gotBytes[$];
  int         creditSeen = 0;

  always @(negedge clk) begin
    if (modelLive) begin
      if (valid_out && ready) gotBytes.push_back(data_out);
      if (lnk_credit) creditSeen++;
    end
  end

  // Inputs change 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic sendWord(input logic [3:0] w);
    tick();
    lnk_valid = 1'b1;
    lnk_data  = w;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    sendWord({b[5:4], b[1:0]});
    sendWord({b[7:6], b[3:2]});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      lnk_valid = 1'b0;
    end
  endtask

  task automatic doReset();
    tick();
    rst_n     = 1'b0;
    lnk_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    gotBytes.delete();
    creditSeen = 0;
  endtask

  task automatic checkBytes(input string name, input logic [7:0] exp[$]);
    checkOutput({name, "_count"}, gotBytes.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < gotBytes.size()) checkOutput(name, gotBytes[i], exp[i]);
    end
  endtask

  logic [7:0] seq[$];

  initial begin
    rst_n     = 1'b0;
    lnk_valid = 1'b0;
    lnk_data  = '0;
    ready     = 1'b1;

    @(negedge clk);
    checkOutput("reset_data_out", data_out, 8'h00);
    checkOutput("reset_valid_out", valid_out, 1'b0);
    checkOutput("reset_lnk_credit", lnk_credit, 1'b0);
    checkOutput("reset_ovf_err", ovf_err, 1'b0);
    tick();
    rst_n = 1'b1;

    $display("[TB] single byte");
    doReset();
    applyStimulus(8'h3C);
    idle(2);
    @(negedge clk);
    checkOutput("single_valid", valid_out, 1'b1);
    checkOutput("single_data", data_out, 8'h3C);
    tick();
    @(negedge clk);
    checkOutput("single_valid_clear", valid_out, 1'b0);
    idle(3);
    checkOutput("single_credits", creditSeen, 0);

    $display("[TB] credit return");
    doReset();
    ready = 1'b1;
    seq = '{8'h01, 8'h02, 8'h03, 8'h04};
    foreach (seq[i]) applyStimulus(seq[i]);
    idle(8);
    checkBytes("credit_bytes", seq);
    checkOutput("credit_pulses", creditSeen, 2);

    $display("[TB] back-pressure");
    doReset();
    ready = 1'b0;
    seq = '{8'hFF, 8'h00, 8'hA5, 8'h5A};
    foreach (seq[i]) applyStimulus(seq[i]);
    idle(3);
    repeat (4) begin
      @(negedge clk);
      checkOutput("bp_hold_valid", valid_out, 1'b1);
      checkOutput("bp_hold_data", data_out, 8'hFF);
      tick();
    end
    ready = 1'b1;
    idle(12);
    checkBytes("bp_bytes", seq);

    // Two words sit in the read path, so ten words fit before the FIFO fills.
    $display("[TB] overflow");
    doReset();
    ready = 1'b0;
    seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    foreach (seq[i]) applyStimulus(seq[i]);
    idle(3);
    @(negedge clk);
`ifdef OFF_CHIP_RX_OVF_CHECK_EN
    checkOutput("ovf_flag", ovf_err, 1'b1);
`else
    checkOutput("ovf_flag", ovf_err, 1'b0);
`endif
    checkOutput("ovf_first_byte", data_out, 8'h11);
    tick();
    ready = 1'b1;
    idle(20);
    seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    checkBytes("ovf_bytes", seq);
    @(negedge clk);
`ifdef OFF_CHIP_RX_OVF_CHECK_EN
    checkOutput("ovf_sticky", ovf_err, 1'b1);
`else
    checkOutput("ovf_sticky", ovf_err, 1'b0);
`endif

    $display("[TB] reset mid-byte");
    doReset();
    ready = 1'b1;
    sendWord(4'hC);
    tick();
    lnk_valid = 1'b0;
    rst_n     = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_data_out", data_out, 8'h00);
    checkOutput("midrst_valid_out", valid_out, 1'b0);
    checkOutput("midrst_lnk_credit", lnk_credit, 1'b0);
    checkOutput("midrst_ovf_err", ovf_err, 1'b0);
    gotBytes.delete();
    sendWord(4'h9);
    sendWord(4'h9);
    idle(6);
    seq = '{8'hA5};
    checkBytes("midrst_bytes", seq);
    checkOutput("midrst_credits", creditSeen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
